// File: rtl/pipe_sync_sink.sv
// Receiver at the tail of the async req/ack pipeline: it synchronizes req_in, runs a
// four-phase handshake and buffers each accepted token in a show-ahead FIFO.
module pipe_sync_sink #(
   parameter int WIDTH       = 3,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_in,
   input  logic [WIDTH-1:0]         data_in,
   output logic                     ack_out,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               tok_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      IDLE,
      ACKED
   } state_t;

   state_t                 state_q, state_d;
   logic                   ack_q, ack_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [PW-1:0]          wrPtr_q, wrPtr_d;
   logic [PW-1:0]          rdPtr_q, rdPtr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [7:0]             tokCnt_q, tokCnt_d;
   logic [WIDTH-1:0]       mem_q [DEPTH];

   logic reqS;
   logic full;
   logic wrEn;
   logic rdEn;

   assign reqS = sync_q[SYNC_STAGES-1];
   assign full = (count_q == CW'(DEPTH));
   assign rdEn = (count_q != '0) && dout_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
      end
   end

   // data_in is held stable by upstream until ack rises, so it is captured unsynchronized
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      wrEn    = 1'b0;
      case (state_q)
         IDLE: begin
            if (reqS && !full) begin
               wrEn    = 1'b1;
               state_d = ACKED;
               ack_d   = 1'b1;
            end
         end
         ACKED: begin
            if (!reqS) begin
               state_d = IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      wrPtr_d  = wrPtr_q + PW'(wrEn);
      rdPtr_d  = rdPtr_q + PW'(rdEn);
      count_d  = count_q + CW'(wrEn) - CW'(rdEn);
      tokCnt_d = tokCnt_q + 8'(wrEn);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ack_q    <= 1'b0;
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         tokCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         count_q  <= count_d;
         tokCnt_q <= tokCnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem_q[wrPtr_q] <= data_in;
      end
   end

   assign ack_out    = ack_q;
   assign dout_valid = (count_q != '0);
   assign dout       = dout_valid ? mem_q[rdPtr_q] : '0;
   assign count      = count_q;
   assign tok_cnt    = tokCnt_q;

endmodule

// File: tb/tb_pipe_sync_sink.sv
// Bench for pipe_sync_sink: directed handshake scenarios plus randomized token traffic,
// all checked against a queue-based model of the accepted token stream.
module tb_pipe_sync_sink;

   localparam int WIDTH       = 3;
   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   req_in;
   logic [WIDTH-1:0]       data_in;
   logic                   ack_out;
   logic [WIDTH-1:0]       dout;
   logic                   dout_valid;
   logic                   dout_ready;
   logic [$clog2(DEPTH):0] count;
   logic [7:0]             tok_cnt;

   int               nCompared   = 0;
   int               nMismatched = 0;
   logic [WIDTH-1:0] modelQ [$];
   int               modelTok    = 0;
   logic             prevAck     = 1'b0;

   pipe_sync_sink #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .data_in   (data_in),
      .ack_out   (ack_out),
      .dout      (dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .count     (count),
      .tok_cnt   (tok_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic [WIDTH-1:0] d, input logic rdy);
      req_in     = req;
      data_in    = d;
      dout_ready = rdy;
   endtask

   // An ack rise marks a write on the edge just passed; a read happened if the model was non-empty with ready high
   task automatic checkOutput();
      bit ackRose;
      bit readHappened;
      if (rst) begin
         modelQ.delete();
         modelTok = 0;
         prevAck  = 1'b0;
         check("rstAck",   ack_out,    0);
         check("rstValid", dout_valid, 0);
         check("rstCount", count,      0);
         check("rstTok",   tok_cnt,    0);
         check("rstDout",  dout,       0);
         return;
      end
      ackRose      = ack_out && !prevAck;
      readHappened = (modelQ.size() > 0) && dout_ready;
      if (ackRose) check("writeWhileFull", modelQ.size() < DEPTH, 1);
      if (readHappened) void'(modelQ.pop_front());
      if (ackRose) begin
         modelQ.push_back(data_in);
         modelTok++;
      end
      prevAck = ack_out;
      check("count",     count,      modelQ.size());
      check("doutValid", dout_valid, modelQ.size() != 0);
      check("tokCnt",    tok_cnt,    modelTok % 256);
      if (modelQ.size() > 0) check("dout", dout, modelQ[0]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic waitAck(input logic level, input int budget, input string tag);
      int n = 0;
      while (ack_out !== level && n < budget) begin
         tick();
         n++;
      end
      check(tag, ack_out, level);
   endtask

   task automatic sendToken(input logic [WIDTH-1:0] d, input logic rdy);
      applyStimulus(1'b1, d, rdy);
      waitAck(1'b1, 40, "ackRise");
      applyStimulus(1'b0, d, rdy);
      waitAck(1'b0, 40, "ackFall");
   endtask

   task automatic drain();
      dout_ready = 1'b1;
      repeat (DEPTH + 2) tick();
      dout_ready = 1'b0;
      check("drainedCount", count, 0);
   endtask

   initial begin
      logic [WIDTH-1:0] drainExp [4];
      drainExp = '{3'd2, 3'd3, 3'd4, 3'd7};

      applyStimulus(1'b0, '0, 1'b0);
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // single token: accept and release latency
      applyStimulus(1'b1, 3'b101, 1'b0);
      tick(); check("acceptLat1", ack_out, 0);
      tick(); check("acceptLat2", ack_out, 0);
      tick(); check("acceptLat3", ack_out, 1);
      check("firstDout", dout, 5);
      check("firstValid", dout_valid, 1);
      applyStimulus(1'b0, 3'b101, 1'b0);
      tick(); check("releaseLat1", ack_out, 1);
      tick(); check("releaseLat2", ack_out, 1);
      tick(); check("releaseLat3", ack_out, 0);
      check("firstTok", tok_cnt, 1);
      check("firstCount", count, 1);
      drain();

      // fill, stall the fifth token, unblock with a single read
      for (int i = 1; i <= 4; i++) sendToken(WIDTH'(i), 1'b0);
      check("fullCount", count, 4);
      applyStimulus(1'b1, 3'd7, 1'b0);
      repeat (10) begin
         tick();
         check("stallAck", ack_out, 0);
      end
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      check("advanceDout", dout, 2);
      check("sameEdgeNoWrite", ack_out, 0);
      waitAck(1'b1, 10, "stallRelease");
      check("refillCount", count, 4);
      applyStimulus(1'b0, 3'd7, 1'b0);
      waitAck(1'b0, 10, "stallFall");
      for (int k = 0; k < 4; k++) begin
         check("drainOrder", dout, drainExp[k]);
         dout_ready = 1'b1;
         tick();
         dout_ready = 1'b0;
      end
      check("afterDrainCount", count, 0);

      // held request gives exactly one write
      applyStimulus(1'b1, 3'd6, 1'b0);
      waitAck(1'b1, 10, "heldRise");
      repeat (20) begin
         tick();
         check("heldAck", ack_out, 1);
      end
      check("heldCount", count, 1);
      applyStimulus(1'b0, 3'd6, 1'b0);
      waitAck(1'b0, 10, "heldFall");
      drain();

      // random data and random consumer readiness
      repeat (40) begin
         logic rdy;
         rdy = 1'($urandom);
         if (modelQ.size() == DEPTH) rdy = 1'b1;
         sendToken(WIDTH'($urandom_range(0, 7)), rdy);
         repeat ($urandom_range(0, 2)) tick();
      end
      drain();

      // streaming from a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 300; i++) sendToken(WIDTH'(i % 8), 1'b1);
      repeat (4) tick();
      check("streamTok", tok_cnt, 44);
      check("streamCount", count, 0);
      dout_ready = 1'b0;

      // reset while ACKED with two tokens stored; request stays high across reset
      sendToken(3'd1, 1'b0);
      applyStimulus(1'b1, 3'd2, 1'b0);
      waitAck(1'b1, 10, "midAck");
      check("midCount", count, 2);
      rst = 1'b1;
      tick();
      check("midRstAck", ack_out, 0);
      check("midRstCount", count, 0);
      check("midRstValid", dout_valid, 0);
      check("midRstTok", tok_cnt, 0);
      applyStimulus(1'b1, 3'd3, 1'b0);
      rst = 1'b0;
      waitAck(1'b1, 10, "postRstAck");
      check("postRstCount", count, 1);
      check("postRstTok", tok_cnt, 1);
      check("postRstDout", dout, 3);
      applyStimulus(1'b0, 3'd3, 1'b0);
      waitAck(1'b0, 10, "postRstFall");
      drain();

      // ready while empty is ignored
      dout_ready = 1'b1;
      repeat (5) begin
         tick();
         check("emptyCount", count, 0);
         check("emptyValid", dout_valid, 0);
      end
      dout_ready = 1'b0;
      sendToken(3'd4, 1'b0);
      check("afterEmptyDout", dout, 4);
      check("afterEmptyCount", count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
